// File: rtl/divider_controller.sv
// Sequencing FSM for the 10-bit restoring divider datapath: start/done handshake,
// operand load, init, iteration stepping, and divide-by-zero / overflow abort.
module divider_controller #(
  parameter bit OVF_ABORT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic dvz,
  input  logic ovf,
  input  logic cout,
  output logic ld_a,
  output logic ld_b,
  output logic ld_q,
  output logic ld_acc,
  output logic sel_q,
  output logic sel_acc,
  output logic init_counter,
  output logic cnt_up,
  output logic ready,
  output logic busy,
  output logic done,
  output logic err_dvz,
  output logic err_ovf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INIT = 3'd2,
    S_CALC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic ld_a;
    logic ld_b;
    logic ld_q;
    logic ld_acc;
    logic sel_q;
    logic sel_acc;
    logic init_counter;
    logic cnt_up;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{ready: 1'b1, default: 1'b0};

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   err_dvz_q, err_dvz_d;
  logic   err_ovf_q, err_ovf_d;

  // Next-state and sticky error flag update
  always_comb begin
    state_d   = state_q;
    err_dvz_d = err_dvz_q;
    err_ovf_d = err_ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_ovf_d = 1'b0;
          if (dvz) begin
            state_d   = S_DONE;
            err_dvz_d = 1'b1;
          end else begin
            state_d   = S_LOAD;
            err_dvz_d = 1'b0;
          end
        end
      end
      S_LOAD: state_d = S_INIT;
      S_INIT: state_d = S_CALC;
      S_CALC: begin
        // Overflow outranks the terminal count on the same step
        if (OVF_ABORT && ovf) begin
          state_d   = S_DONE;
          err_ovf_d = 1'b1;
        end else if (cout) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode of the upcoming state so the outputs leave a register
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_IDLE: ctrl_d.ready = 1'b1;
      S_LOAD: begin
        ctrl_d.busy         = 1'b1;
        ctrl_d.ld_a         = 1'b1;
        ctrl_d.ld_b         = 1'b1;
        ctrl_d.init_counter = 1'b1;
      end
      S_INIT: begin
        ctrl_d.busy    = 1'b1;
        ctrl_d.ld_q    = 1'b1;
        ctrl_d.ld_acc  = 1'b1;
        ctrl_d.sel_q   = 1'b1;
        ctrl_d.sel_acc = 1'b1;
      end
      S_CALC: begin
        ctrl_d.busy   = 1'b1;
        ctrl_d.ld_q   = 1'b1;
        ctrl_d.ld_acc = 1'b1;
        ctrl_d.cnt_up = 1'b1;
      end
      S_DONE:  ctrl_d.done = 1'b1;
      default: ctrl_d.ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= CTRL_RESET;
      err_dvz_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      err_dvz_q <= err_dvz_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign ready        = ctrl_q.ready;
  assign busy         = ctrl_q.busy;
  assign done         = ctrl_q.done;
  assign ld_a         = ctrl_q.ld_a;
  assign ld_b         = ctrl_q.ld_b;
  assign ld_q         = ctrl_q.ld_q;
  assign ld_acc       = ctrl_q.ld_acc;
  assign sel_q        = ctrl_q.sel_q;
  assign sel_acc      = ctrl_q.sel_acc;
  assign init_counter = ctrl_q.init_counter;
  assign cnt_up       = ctrl_q.cnt_up;
  assign err_dvz      = err_dvz_q;
  assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_divider_controller.sv
// Bench for divider_controller: two instances (overflow abort on/off) checked each
// cycle against an operation schedule derived from start/dvz/ovf timing.
module tb_divider_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0;
  logic start0 = 1'b0;
  logic dvz = 1'b0;
  logic ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  logic p_dvz1 = 1'b0, p_ovf1 = 1'b0, p_dvz0 = 1'b0, p_ovf0 = 1'b0;

  always #5 clk = ~clk;

  logic ld_a1, ld_b1, ld_q1, ld_acc1, sel_q1, sel_acc1, init1, up1;
  logic ready1, busy1, done1, edvz1, eovf1, cout1;
  logic ld_a0, ld_b0, ld_q0, ld_acc0, sel_q0, sel_acc0, init0, up0;
  logic ready0, busy0, done0, edvz0, eovf0, cout0;
  logic [3:0] cnt1, cnt0;

  divider_controller #(.OVF_ABORT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dvz(dvz), .ovf(ovf), .cout(cout1),
    .ld_a(ld_a1), .ld_b(ld_b1), .ld_q(ld_q1), .ld_acc(ld_acc1),
    .sel_q(sel_q1), .sel_acc(sel_acc1), .init_counter(init1), .cnt_up(up1),
    .ready(ready1), .busy(busy1), .done(done1), .err_dvz(edvz1), .err_ovf(eovf1)
  );

  divider_controller #(.OVF_ABORT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dvz(dvz), .ovf(ovf), .cout(cout0),
    .ld_a(ld_a0), .ld_b(ld_b0), .ld_q(ld_q0), .ld_acc(ld_acc0),
    .sel_q(sel_q0), .sel_acc(sel_acc0), .init_counter(init0), .cnt_up(up0),
    .ready(ready0), .busy(busy0), .done(done0), .err_dvz(edvz0), .err_ovf(eovf0)
  );

  // Datapath iteration counter: load 2, count up, terminal count at 15
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt1 <= 4'd0;
    else if (init1) cnt1 <= 4'd2;
    else if (up1) cnt1 <= cnt1 + 4'd1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt0 <= 4'd0;
    else if (init0) cnt0 <= 4'd2;
    else if (up0) cnt0 <= cnt0 + 4'd1;
  end
  assign cout1 = (cnt1 == 4'hF);
  assign cout0 = (cnt0 == 4'hF);

  wire [12:0] obs1 = {ready1, busy1, done1, ld_a1, ld_b1, ld_q1, ld_acc1,
                      sel_q1, sel_acc1, init1, up1, edvz1, eovf1};
  wire [12:0] obs0 = {ready0, busy0, done0, ld_a0, ld_b0, ld_q0, ld_acc0,
                      sel_q0, sel_acc0, init0, up0, edvz0, eovf0};

  localparam logic [12:0] RESET_VEC = 13'b100_00000000_00;

  // Expected outputs in cycle c of an operation that completes in cycle d
  function automatic logic [12:0] exp_vec(int c, int d, logic e_dz, logic e_ov);
    logic [10:0] f;
    if (c == 0 || c > d) f = 11'b100_00000000;
    else if (c == d)     f = 11'b001_00000000;
    else if (c == 1)     f = 11'b010_11000010;
    else if (c == 2)     f = 11'b010_00111100;
    else                 f = 11'b010_00110001;
    return {f, e_dz, e_ov};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("idle1 i=%0d", i), obs1, exp_vec(0, 0, p_dvz1, p_ovf1));
      check($sformatf("idle0 i=%0d", i), obs0, exp_vec(0, 0, p_dvz0, p_ovf0));
      start1 = 1'b0;
      start0 = 1'b0;
      ovf    = 1'b0;
      dvz    = 1'($urandom);
    end
  endtask

  // One operation; ovf pulses for one cycle at cycle ovf_at (0 = never)
  task automatic run_op(input bit dz, input int ovf_at, input bit hold_in);
    bit hold;
    bit in_calc;
    int d1, d0;
    logic eo1;
    logic [1:0] e1, e0;
    in_calc = (ovf_at >= 3 && ovf_at <= 16);
    d1   = dz ? 1 : (in_calc ? ovf_at + 1 : 17);
    d0   = dz ? 1 : 17;
    eo1  = !dz && in_calc;
    hold = hold_in && (d1 == d0);
    for (int c = 0; c <= d0; c++) begin
      @(negedge clk);
      e1 = (c == 0) ? {p_dvz1, p_ovf1} : (c < d1) ? 2'b00 : {dz, eo1};
      e0 = (c == 0) ? {p_dvz0, p_ovf0} : (c < d0) ? 2'b00 : {dz, 1'b0};
      check($sformatf("dut1 c=%0d d=%0d", c, d1), obs1, exp_vec(c, d1, e1[1], e1[0]));
      check($sformatf("dut0 c=%0d d=%0d", c, d0), obs0, exp_vec(c, d0, e0[1], e0[0]));
      if (c == 0) begin
        start1 = 1'b1;
        start0 = 1'b1;
        dvz    = dz;
        ovf    = 1'b0;
      end else begin
        dvz    = 1'($urandom);
        ovf    = (c == ovf_at);
        start1 = hold ? 1'b1 : (c <= d1 ? 1'($urandom) : 1'b0);
        start0 = hold ? 1'b1 : (c <= d0 ? 1'($urandom) : 1'b0);
      end
    end
    p_dvz1 = dz;
    p_ovf1 = eo1;
    p_dvz0 = dz;
    p_ovf0 = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("reset1", obs1, RESET_VEC);
    check("reset0", obs0, RESET_VEC);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    run_op(1'b0, 0, 1'b0);     // plain 100/7-style run, 17-cycle latency
    run_op(1'b1, 0, 1'b0);     // divide by zero: done in cycle 1, no loads
    run_op(1'b0, 0, 1'b0);     // error flags clear on next valid start
    run_op(1'b0, 9, 1'b0);     // overflow at cycle 9
    idle_cycles(1);
    run_op(1'b0, 16, 1'b0);    // overflow together with terminal count
    run_op(1'b0, 2, 1'b0);     // overflow outside CALC is ignored
    for (int k = 0; k < 3; k++) run_op(1'b0, 0, 1'b1);  // start held high
    run_op(1'b1, 0, 1'b1);
    idle_cycles(1);

    // Reset dropped in the middle of CALC
    @(negedge clk);
    check("pre_rst1", obs1, exp_vec(0, 17, p_dvz1, p_ovf1));
    check("pre_rst0", obs0, exp_vec(0, 17, p_dvz0, p_ovf0));
    start1 = 1'b1;
    start0 = 1'b1;
    dvz    = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("mid1 c=%0d", c), obs1, exp_vec(c, 17, 1'b0, 1'b0));
      check($sformatf("mid0 c=%0d", c), obs0, exp_vec(c, 17, 1'b0, 1'b0));
      start1 = 1'b0;
      start0 = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst1", obs1, RESET_VEC);
    check("async_rst0", obs0, RESET_VEC);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("hold_rst1 i=%0d", i), obs1, RESET_VEC);
      check($sformatf("hold_rst0 i=%0d", i), obs0, RESET_VEC);
    end
    rst = 1'b1;
    p_dvz1 = 1'b0; p_ovf1 = 1'b0; p_dvz0 = 1'b0; p_ovf0 = 1'b0;
    run_op(1'b0, 0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      bit dz;
      bit hold;
      int oat;
      dz   = ($urandom_range(0, 4) == 0);
      oat  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
      hold = 1'($urandom);
      run_op(dz, oat, hold);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
